// File: rtl/display_pkg.sv
// Shared display types: 24-bit pixel, frame defaults, reader FSM states and FIFO entry.
package display_pkg;

    typedef logic [23:0] pixel_t;

    localparam int DEFAULT_FRAME_PIXELS = 10000;
    localparam int DEFAULT_FRAME_WIDTH  = 100;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;

    typedef struct packed {
        logic   sof;
        logic   eol;
        pixel_t pix;
    } fifo_entry_t;

endpackage

// File: rtl/pix_skid_fifo.sv
// Two-entry FIFO of {sof, eol, pixel}; head is presented combinationally from storage.
module pix_skid_fifo
    import display_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  fifo_entry_t push_data,
    input  logic        pop,
    output fifo_entry_t head,
    output logic [1:0]  count
);

    fifo_entry_t mem_reg [2];
    logic        wr_ptr_reg;
    logic        rd_ptr_reg;
    logic [1:0]  count_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (reset) begin
                    mem_reg[gi] <= '0;
                end else if (push && (wr_ptr_reg == 1'(gi))) begin
                    mem_reg[gi] <= push_data;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            // Push and pop together leave occupancy unchanged.
            if (push && !pop) begin
                count_reg <= count_reg + 2'd1;
            end else if (pop && !push) begin
                count_reg <= count_reg - 2'd1;
            end
        end
    end

    assign head  = mem_reg[rd_ptr_reg];
    assign count = count_reg;

endmodule

// File: rtl/frame_buf_reader.sv
// Frame buffer scan-out: reads one frame and streams it as valid/ready pixels.
// Optional FRAME_READER_TEST_PATTERN_EN adds test_mode, which replaces buffer reads with a generated pattern.
module frame_buf_reader
    import display_pkg::*;
#(
    parameter int FRAME_PIXELS = DEFAULT_FRAME_PIXELS,
    parameter int FRAME_WIDTH  = DEFAULT_FRAME_WIDTH,
    parameter int ADDR_W       = 20
) (
    input  logic              clk,
    input  logic              reset,
`ifdef FRAME_READER_TEST_PATTERN_EN
    input  logic              test_mode,
`endif
    input  logic              buf_full,
    output logic              buf_empty,
    output logic              re,
    output logic [ADDR_W-1:0] addr,
    input  logic [7:0]        r_in,
    input  logic [7:0]        g_in,
    input  logic [7:0]        b_in,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic [23:0]       pix_data,
    output logic              sof,
    output logic              eol,
    output logic              busy
);

    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] NUM_PIX  = CNT_W'(FRAME_PIXELS);
    localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(FRAME_PIXELS - 1);
    localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(FRAME_WIDTH - 1);

    state_t             state_reg;
    logic [CNT_W-1:0]   rd_cnt_reg;
    logic [CNT_W-1:0]   out_cnt_reg;
    logic [CNT_W-1:0]   cap_cnt_reg;
    logic [CNT_W-1:0]   col_cnt_reg;
    logic               inflight_reg;
    logic               buf_empty_reg;
    logic               armed_reg;
    logic [ADDR_W-1:0]  addr_reg;
    logic               use_pattern;

    logic               fire;
    logic               push;
    logic               pop;
    logic [1:0]         fifo_count;
    fifo_entry_t        push_data;
    fifo_entry_t        head;
    pixel_t             pattern_pix;

`ifdef FRAME_READER_TEST_PATTERN_EN
    logic test_mode_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            test_mode_reg <= 1'b0;
        end else if (state_reg == IDLE) begin
            test_mode_reg <= test_mode;
        end
    end

    assign use_pattern = test_mode_reg;
`else
    assign use_pattern = 1'b0;
`endif

    assign pix_valid = (fifo_count != 2'd0);
    assign pop       = pix_valid & pix_ready;

    // Slot reservation: stored entries plus the read in flight, less this cycle's pop, must leave room.
    assign fire = (state_reg == STREAM) && (rd_cnt_reg < NUM_PIX) &&
                  (({1'b0, fifo_count} + {2'b00, inflight_reg}) < (3'd2 + {2'b00, pop}));
    assign re   = fire & ~use_pattern;
    assign push = inflight_reg;

    assign addr = re ? rd_cnt_reg[ADDR_W-1:0] : addr_reg;

    assign pattern_pix   = {cap_cnt_reg[7:0], ~cap_cnt_reg[7:0], 8'h00};
    assign push_data.sof = (cap_cnt_reg == '0);
    assign push_data.eol = (col_cnt_reg == LAST_COL);
    assign push_data.pix = use_pattern ? pattern_pix : {r_in, g_in, b_in};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            rd_cnt_reg    <= '0;
            out_cnt_reg   <= '0;
            cap_cnt_reg   <= '0;
            col_cnt_reg   <= '0;
            inflight_reg  <= 1'b0;
            buf_empty_reg <= 1'b1;
            armed_reg     <= 1'b1;
            addr_reg      <= '0;
        end else begin
            inflight_reg <= fire;
            addr_reg     <= addr;

            case (state_reg)
                IDLE: begin
                    if (buf_full && armed_reg) begin
                        state_reg     <= STREAM;
                        buf_empty_reg <= 1'b0;
                        rd_cnt_reg    <= '0;
                        out_cnt_reg   <= '0;
                        cap_cnt_reg   <= '0;
                        col_cnt_reg   <= '0;
                    end
                end
                STREAM: begin
                    if (fire) begin
                        rd_cnt_reg <= rd_cnt_reg + 1'b1;
                    end
                    if (push) begin
                        cap_cnt_reg <= cap_cnt_reg + 1'b1;
                        col_cnt_reg <= (col_cnt_reg == LAST_COL) ? '0 : col_cnt_reg + 1'b1;
                    end
                    if (pop) begin
                        out_cnt_reg <= out_cnt_reg + 1'b1;
                        if (out_cnt_reg == LAST_PIX) begin
                            state_reg <= DONE;
                        end
                    end
                end
                DONE: begin
                    buf_empty_reg <= 1'b1;
                    armed_reg     <= 1'b0;
                    state_reg     <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase

            // A sampled low buf_full means the writer has taken the buffer back; allow the next frame.
            if (!buf_full) begin
                armed_reg <= 1'b1;
            end
        end
    end

    pix_skid_fifo u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .count     (fifo_count)
    );

    assign pix_data  = head.pix;
    assign sof       = head.sof;
    assign eol       = head.eol;
    assign buf_empty = buf_empty_reg;
    assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_frame_buf_reader.sv
// Randomized self-checking bench for frame_buf_reader with a 16-pixel, 4-wide frame.
module tb_frame_buf_reader;

    localparam int FP = 16;
    localparam int FW = 4;
    localparam int AW = 20;

    logic          clk;
    logic          reset;
    logic          buf_full;
    logic          buf_empty;
    logic          re;
    logic [AW-1:0] addr;
    logic [7:0]    r_in;
    logic [7:0]    g_in;
    logic [7:0]    b_in;
    logic          pix_valid;
    logic          pix_ready;
    logic [23:0]   pix_data;
    logic          sof;
    logic          eol;
    logic          busy;
`ifdef FRAME_READER_TEST_PATTERN_EN
    logic          test_mode;
`endif

    frame_buf_reader #(
        .FRAME_PIXELS (FP),
        .FRAME_WIDTH  (FW),
        .ADDR_W       (AW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
`ifdef FRAME_READER_TEST_PATTERN_EN
        .test_mode (test_mode),
`endif
        .buf_full  (buf_full),
        .buf_empty (buf_empty),
        .re        (re),
        .addr      (addr),
        .r_in      (r_in),
        .g_in      (g_in),
        .b_in      (b_in),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_data  (pix_data),
        .sof       (sof),
        .eol       (eol),
        .busy      (busy)
    );

    int   checks = 0;
    int   errors = 0;
    int   beat_cnt = 0;
    int   rd_cnt = 0;
    int   frames_done = 0;
    int   re_total = 0;
    int   ready_mode = 0;
    int   ready_phase = 0;
    logic tm = 1'b0;
    logic [23:0] mem [FP];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference pixel for stream position k.
    function automatic logic [23:0] exp_pix(input int k);
        logic [7:0] lo;
        lo = k[7:0];
        if (tm) return {lo, ~lo, 8'h00};
        return 24'(32'h010203 * k);
    endfunction

    initial begin
        for (int i = 0; i < FP; i++) mem[i] = 24'(32'h010203 * i);
        r_in = 8'h00;
        g_in = 8'h00;
        b_in = 8'h00;
    end

    // Buffer model: registered read, data valid the cycle after re.
    always @(posedge clk) begin
        if (re) {r_in, g_in, b_in} <= mem[addr[3:0]];
    end

    initial begin
        pix_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: pix_ready = 1'b1;
                1: begin
                    pix_ready = (ready_phase == 0) || (ready_phase == 3);
                    ready_phase = (ready_phase + 1) % 4;
                end
                2: pix_ready = 1'($urandom_range(0, 1));
                default: ;
            endcase
        end
    end

    // Monitor: scoreboard of accepted beats, address sequence, FIFO bound and stall stability.
    initial begin
        logic        stall;
        logic [25:0] prev;
        stall = 1'b0;
        prev  = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                beat_cnt = 0;
                rd_cnt   = 0;
                stall    = 1'b0;
            end else begin
                if (tm) check_val("re_in_test_mode", 32'(re), 32'd0);
                if (re) begin
                    re_total++;
                    check_val("rd_limit", 32'(rd_cnt < FP), 32'd1);
                    check_val("addr", 32'(addr), 32'(rd_cnt));
                    rd_cnt++;
                    check_val("outstanding_le2",
                              32'((rd_cnt - beat_cnt - int'(pix_valid & pix_ready)) <= 2), 32'd1);
                end
                if (stall) begin
                    check_val("hold_valid", 32'(pix_valid), 32'd1);
                    check_val("hold_data", 32'({sof, eol, pix_data}), 32'(prev));
                end
                if (pix_valid) begin
                    if (pix_ready) begin
                        check_val("pix_data", 32'(pix_data), 32'(exp_pix(beat_cnt)));
                        check_val("sof", 32'(sof), 32'(beat_cnt == 0));
                        check_val("eol", 32'(eol), 32'(((beat_cnt + 1) % FW) == 0));
                        if (tm && beat_cnt == 5) check_val("pattern_px5", 32'(pix_data), 32'h05FA00);
                        beat_cnt++;
                        if (beat_cnt == FP) begin
                            frames_done++;
                            beat_cnt = 0;
                            rd_cnt   = 0;
                        end
                        stall = 1'b0;
                    end else begin
                        stall = 1'b1;
                        prev  = {sof, eol, pix_data};
                    end
                end else begin
                    stall = 1'b0;
                end
            end
        end
    end

    task automatic wait_frame(input int f0, input int budget, output int cycles);
        cycles = 0;
        while ((frames_done == f0) && (cycles < budget)) begin
            @(posedge clk);
            #2;
            cycles++;
        end
        check_val("frame_done", 32'(frames_done - f0), 32'd1);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        int f0;
        int cyc;
        int re0;
        int n;
        reset    = 1'b1;
        buf_full = 1'b0;
`ifdef FRAME_READER_TEST_PATTERN_EN
        test_mode = 1'b0;
`endif
        idle_cycles(3);
        check_val("rst_buf_empty", 32'(buf_empty), 32'd1);
        check_val("rst_re", 32'(re), 32'd0);
        check_val("rst_addr", 32'(addr), 32'd0);
        check_val("rst_pix_valid", 32'(pix_valid), 32'd0);
        check_val("rst_pix_data", 32'(pix_data), 32'd0);
        check_val("rst_sof", 32'(sof), 32'd0);
        check_val("rst_eol", 32'(eol), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        idle_cycles(1);

        // Frame 1: full throughput.
        ready_mode = 0;
        buf_full = 1'b1;
        f0 = frames_done;
        idle_cycles(1);
        check_val("start_buf_empty", 32'(buf_empty), 32'd0);
        check_val("start_busy", 32'(busy), 32'd1);
        check_val("start_re", 32'(re), 32'd1);
        check_val("start_addr", 32'(addr), 32'd0);
        wait_frame(f0, 200, cyc);
        check_val("frame_latency", 32'(cyc), 32'd18);
        idle_cycles(1);
        check_val("done_buf_empty", 32'(buf_empty), 32'd1);
        check_val("done_busy", 32'(busy), 32'd0);

        // buf_full still high: no second frame.
        re0 = re_total;
        f0 = frames_done;
        idle_cycles(20);
        check_val("no_rearm_re", 32'(re_total - re0), 32'd0);
        check_val("no_rearm_frames", 32'(frames_done - f0), 32'd0);
        check_val("no_rearm_buf_empty", 32'(buf_empty), 32'd1);

        // Frame 2: ready pattern 1,0,0,1 after re-arming.
        buf_full = 1'b0;
        idle_cycles(2);
        ready_mode = 1;
        ready_phase = 0;
        buf_full = 1'b1;
        wait_frame(frames_done, 300, cyc);
        idle_cycles(2);
        check_val("f2_buf_empty", 32'(buf_empty), 32'd1);

        // Frame 3: random ready, buf_full dropped at pixel 5.
        buf_full = 1'b0;
        idle_cycles(1);
        ready_mode = 2;
        buf_full = 1'b1;
        f0 = frames_done;
        n = 0;
        while (beat_cnt < 5 && frames_done == f0 && n < 300) begin
            idle_cycles(1);
            n++;
        end
        check_val("reach_px5", 32'(beat_cnt >= 5), 32'd1);
        buf_full = 1'b0;
        wait_frame(f0, 300, cyc);
        idle_cycles(4);
        check_val("f3_idle", 32'(busy), 32'd0);

        // Reset mid-frame at pixel 7 with pix_ready low.
        ready_mode = 0;
        buf_full = 1'b1;
        n = 0;
        while (beat_cnt != 7 && n < 300) begin
            idle_cycles(1);
            n++;
        end
        check_val("reach_px7", 32'(beat_cnt), 32'd7);
        ready_mode = 4;
        pix_ready = 1'b0;
        reset = 1'b1;
        idle_cycles(1);
        check_val("midrst_pix_valid", 32'(pix_valid), 32'd0);
        check_val("midrst_re", 32'(re), 32'd0);
        check_val("midrst_buf_empty", 32'(buf_empty), 32'd1);
        check_val("midrst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        ready_mode = 0;
        wait_frame(frames_done, 300, cyc);

        // Random back-to-back frames with random idle gaps and random ready.
        for (int k = 0; k < 3; k++) begin
            buf_full = 1'b0;
            idle_cycles($urandom_range(1, 4));
            ready_mode = 2;
            buf_full = 1'b1;
            wait_frame(frames_done, 400, cyc);
        end

`ifdef FRAME_READER_TEST_PATTERN_EN
        buf_full = 1'b0;
        idle_cycles(3);
        tm = 1'b1;
        test_mode = 1'b1;
        re0 = re_total;
        ready_mode = 2;
        buf_full = 1'b1;
        wait_frame(frames_done, 400, cyc);
        check_val("test_mode_no_re", 32'(re_total - re0), 32'd0);
        buf_full = 1'b0;
        idle_cycles(3);
        test_mode = 1'b0;
        tm = 1'b0;
`endif

        idle_cycles(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
